// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the ofifo drain-side collector.
// Optional build macro OFIFO_ERR_FLAG_EN enables the sticky o_err flags in ofifo.
package ofifo_pkg;

    localparam int OFIFO_COL     = 8;
    localparam int OFIFO_PSUM_BW = 16;
    localparam int OFIFO_DEPTH   = 64;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    // Pointer width: one extra MSB beyond the address bits separates full from empty.
    function automatic int ofifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_fifo_col.sv
// fifo_col: single-column first-word-fall-through FIFO used by ofifo.
// Each column is written on its own strobe. The pop arrives already qualified by the
// row-level valid. Storage is not reset; only the pointers are.
module fifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = OFIFO_PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               o_empty,
    output logic               o_full
);

    localparam int PW = ofifo_ptr_w(depth);
    localparam int AW = PW - 1;

    logic [psum_bw-1:0] mem_q [depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               push;
    logic               pop;

    assign o_empty = (rd_ptr_q == wr_ptr_q);
    assign o_full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

    // A push on a full column is still legal when the same edge frees the head slot;
    // the write address then equals the slot being vacated.
    assign pop  = rd && !o_empty;
    assign push = wr && (!o_full || pop);

    assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    assign out = mem_q[rd_ptr_q[AW-1:0]];

    // Storage write; held off during reset so an in-flight strobe leaves no trace.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in;
        end
    end

    // Pointer registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ofifo.sv
// ofifo: drain-end collector for the systolic array. One fifo_col per array column,
// written with skew; rows are popped all columns at once once every column has data.
// Optional build macro OFIFO_ERR_FLAG_EN adds o_err[1:0] (sticky overflow/underflow).
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = OFIFO_COL,
    parameter int psum_bw = OFIFO_PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
`ifdef OFIFO_ERR_FLAG_EN
    ,
    output logic [1:0]             o_err
`endif
);

    logic [col-1:0] col_empty;
    logic [col-1:0] col_full;
    logic           rd_pop;

    for (genvar c = 0; c < col; c++) begin : g_col
        fifo_col #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) u_col (
            .clk    (clk),
            .reset  (reset),
            .wr     (wr[c]),
            .rd     (rd_pop),
            .in     (in[psum_bw*c +: psum_bw]),
            .out    (out[psum_bw*c +: psum_bw]),
            .o_empty(col_empty[c]),
            .o_full (col_full[c])
        );
    end

    assign o_valid = ~|col_empty;
    assign o_full  = |col_full;
    assign o_ready = ~o_full;
    assign rd_pop  = rd & o_valid;

`ifdef OFIFO_ERR_FLAG_EN
    logic [1:0] err_q, err_d;

    // Sticky flags accumulate until reset.
    always_comb begin
        err_d = err_q;
        if (|(wr & col_full) && !rd_pop) begin
            err_d[ERR_OVF] = 1'b1;
        end
        if (rd && !o_valid) begin
            err_d[ERR_UDF] = 1'b1;
        end
    end

    // Error flag register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: directed scenarios plus a randomized run against a
// queue-per-column reference model.
module tb_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic                clk   = 1'b0;
    logic                reset = 1'b0;
    logic [COL*BW-1:0]   in_d  = '0;
    logic [COL-1:0]      wr    = '0;
    logic                rd    = 1'b0;
    logic [COL*BW-1:0]   out;
    logic                o_valid;
    logic                o_full;
    logic                o_ready;
`ifdef OFIFO_ERR_FLAG_EN
    logic [1:0]          o_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] mq [COL][$];
    logic [1:0]    m_err;

    ofifo #(
        .col    (COL),
        .psum_bw(BW),
        .depth  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_d),
        .wr     (wr),
        .rd     (rd),
        .out    (out),
        .o_valid(o_valid),
        .o_full (o_full),
        .o_ready(o_ready)
`ifdef OFIFO_ERR_FLAG_EN
        ,
        .o_err  (o_err)
`endif
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the reference model at the edge, return 1 time unit later.
    task automatic tick(input logic rst_n, input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        bit pop;
        bit full_c;
        reset = rst_n;
        wr    = w;
        in_d  = d;
        rd    = r;
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_err = '0;
        end else begin
            pop = r;
            for (int c = 0; c < COL; c++) if (mq[c].size() == 0) pop = 0;
            if (r && !pop) m_err[1] = 1'b1;
            for (int c = 0; c < COL; c++) begin
                full_c = (mq[c].size() == DEPTH);
                if (pop) void'(mq[c].pop_front());
                if (w[c]) begin
                    if (!full_c || pop) mq[c].push_back(d[c*BW +: BW]);
                    else m_err[0] = 1'b1;
                end
            end
        end
        #1;
        reset = 1'b1;
        wr    = '0;
        rd    = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, COL'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
            checks++;
            if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
            checks++;
            if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
`ifdef OFIFO_ERR_FLAG_EN
            checks++;
            if (o_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", o_err); end
`endif
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, '0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", o_valid); end
        end
    endtask

    task automatic test_skew();
        logic [COL*BW-1:0] d;
        logic [COL*BW-1:0] exp_row;
        tick(1'b0, '0, '0, 1'b0);
        for (int c = 0; c < COL; c++) begin
            d = '0;
            d[c*BW +: BW] = 16'(16'h1000 + c);
            exp_row[c*BW +: BW] = 16'(16'h1000 + c);
            tick(1'b1, COL'(1) << c, d, 1'b0);
            checks++;
            if (o_valid !== (c == COL - 1)) begin
                errors++; $display("FAIL skew_valid col %0d: got %b want %b", c, o_valid, (c == COL - 1));
            end
        end
        checks++;
        if (out !== exp_row) begin errors++; $display("FAIL skew_out: got %h want %h", out, exp_row); end
        tick(1'b1, '0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_drain_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_fill_overflow();
        tick(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            tick(1'b1, '1, {COL{16'(k)}}, 1'b0);
            if (k == DEPTH - 2 || k == DEPTH - 1) begin
                checks++;
                if (o_full !== (k == DEPTH - 1)) begin
                    errors++; $display("FAIL fill_full write %0d: got %b want %b", k + 1, o_full, (k == DEPTH - 1));
                end
            end
        end
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", o_ready); end
        tick(1'b1, '1, {COL{16'hDEAD}}, 1'b0);
        checks++;
        if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", o_full); end
`ifdef OFIFO_ERR_FLAG_EN
        checks++;
        if (o_err !== 2'b01) begin errors++; $display("FAIL ovf_err: got %b want 01", o_err); end
`endif
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (out !== {COL{16'(k)}}) begin errors++; $display("FAIL fill_pop %0d: got %h want %h", k, out, {COL{16'(k)}}); end
            tick(1'b1, '0, '0, 1'b1);
            if (k == 0) begin
                checks++;
                if (o_full !== 1'b0) begin errors++; $display("FAIL fill_unfull: got %b want 0", o_full); end
            end
        end
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_push_pop_full();
        logic [BW-1:0] exp_v;
        tick(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < DEPTH; k++) tick(1'b1, '1, {COL{16'(k)}}, 1'b0);
        tick(1'b1, '1, {COL{16'hBEEF}}, 1'b1);
        checks++;
        if (o_full !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", o_full); end
        checks++;
        if (out !== {COL{16'h0001}}) begin errors++; $display("FAIL pp_head: got %h want %h", out, {COL{16'h0001}}); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_v = (k == DEPTH - 1) ? 16'hBEEF : 16'(k + 1);
            checks++;
            if (out !== {COL{exp_v}}) begin errors++; $display("FAIL pp_pop %0d: got %h want %h", k + 1, out, {COL{exp_v}}); end
            tick(1'b1, '0, '0, 1'b1);
        end
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_underflow();
        logic [COL*BW-1:0] d;
        logic [COL*BW-1:0] exp_row;
        tick(1'b0, '0, '0, 1'b0);
        for (int c = 0; c < COL; c++) begin
            d[c*BW +: BW]       = 16'(16'h2000 + c);
            exp_row[c*BW +: BW] = 16'(16'h2000 + c);
        end
        tick(1'b1, {1'b0, {(COL-1){1'b1}}}, d, 1'b0);
        tick(1'b1, '0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL udf_valid: got %b want 0", o_valid); end
`ifdef OFIFO_ERR_FLAG_EN
        checks++;
        if (o_err !== 2'b10) begin errors++; $display("FAIL udf_err: got %b want 10", o_err); end
`endif
        tick(1'b1, COL'(1) << (COL - 1), d, 1'b0);
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL udf_valid_after: got %b want 1", o_valid); end
        checks++;
        if (out !== exp_row) begin errors++; $display("FAIL udf_head: got %h want %h", out, exp_row); end
    endtask

    task automatic test_reset_mid();
        logic [COL*BW-1:0] d;
        tick(1'b0, '0, '0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'(16'h3000 + r * 16 + c);
            tick(1'b1, '1, d, 1'b0);
        end
        for (int r = 0; r < 3; r++) tick(1'b1, '0, '0, 1'b1);
        for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'(16'h3000 + 3 * 16 + c);
        checks++;
        if (out !== d) begin errors++; $display("FAIL mid_head: got %h want %h", out, d); end
        tick(1'b0, '1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", o_valid); end
        checks++;
        if (o_full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", o_full); end
        tick(1'b1, '1, {COL{16'h00AA}}, 1'b0);
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %b want 1", o_valid); end
        checks++;
        if (out !== {COL{16'h00AA}}) begin errors++; $display("FAIL mid_new_out: got %h want %h", out, {COL{16'h00AA}}); end
        tick(1'b1, '0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_random();
        logic [COL-1:0]    w;
        logic              r;
        logic              rn;
        logic [COL*BW-1:0] d;
        logic [COL*BW-1:0] exp_out;
        bit                exp_valid;
        bit                exp_full;
        bit                wr_heavy;
        tick(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            wr_heavy = ((i / 150) % 2) == 0;
            w  = wr_heavy ? (COL'($urandom) | COL'($urandom)) : (COL'($urandom) & COL'($urandom));
            r  = wr_heavy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
            rn = ($urandom_range(0, 299) != 0);
            d  = {$urandom, $urandom, $urandom, $urandom};
            tick(rn, w, d, r);
            exp_valid = 1;
            exp_full  = 0;
            exp_out   = '0;
            for (int c = 0; c < COL; c++) begin
                if (mq[c].size() == 0) exp_valid = 0;
                else exp_out[c*BW +: BW] = mq[c][0];
                if (mq[c].size() == DEPTH) exp_full = 1;
            end
            checks++;
            if (o_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", i, o_valid, exp_valid); end
            checks++;
            if (o_full !== exp_full) begin errors++; $display("FAIL rnd_full cyc %0d: got %b want %b", i, o_full, exp_full); end
            checks++;
            if (o_ready !== !exp_full) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", i, o_ready, !exp_full); end
            if (exp_valid) begin
                checks++;
                if (out !== exp_out) begin errors++; $display("FAIL rnd_out cyc %0d: got %h want %h", i, out, exp_out); end
            end
`ifdef OFIFO_ERR_FLAG_EN
            checks++;
            if (o_err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d: got %b want %b", i, o_err, m_err); end
`endif
        end
    endtask

    initial begin
        m_err = '0;
        test_reset();
        test_skew();
        test_fill_overflow();
        test_push_pop_full();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
